or3_rr_arbiter: RTL and testbench



---
 rtl/or3_arb_pkg.sv | 15 +
 rtl/MOD_74x32_3.sv | 10 +
 rtl/rr_pick.sv | 33 +++
 rtl/or3_rr_arbiter.sv | 161 ++++++++++++++++
 tb/tb_or3_rr_arbiter.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/or3_arb_pkg.sv
// Shared definitions for the OR3 round-robin arbiter: FSM encoding,
// operand width and grant-counter limits.
package or3_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    localparam int              OPW     = 3;
    localparam int              CNTW    = 8;
    localparam logic [CNTW-1:0] CNT_MAX = 8'hFF;

endpackage

// File: rtl/MOD_74x32_3.sv
// Three-gate slice of a 74x32 quad 2-input OR, used as the shared OR unit.
module MOD_74x32_3 (
    input  logic [2:0] A,
    input  logic [2:0] B,
    output logic [2:0] Y
);

    assign Y = A | B;

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set request bit is found by
// searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1. The wrap uses an explicit
// compare against N, so non-power-of-2 N is handled correctly.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] idx,
    output logic           valid
);

    logic [IDW:0] sum;

    // Scan the requesters in rotated order and keep the first hit.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        sum   = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(N)) begin
                sum = sum - (IDW+1)'(N);
            end
            if (!valid && req[sum[IDW-1:0]]) begin
                valid = 1'b1;
                idx   = sum[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/or3_rr_arbiter.sv
// Round-robin arbiter that shares one MOD_74x32_3 OR unit among N requesters.
// One transaction takes three cycles: grant and operand latch, issue with the
// result registered, then a one-cycle ACK.
// Optional build macro OR3_ARB_STATS_EN adds GNT_CNT, one saturating 8-bit
// grant counter per requester.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | waiting for a request; arbitrate, latch winner's operands
//   S_ISSUE | latched operands drive the shared OR; register Y, raise ACK
//   S_RESP  | ACK visible; advance the round-robin pointer, drop BUSY
module or3_rr_arbiter
    import or3_arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N-1:0]     REQ,
    input  logic [3*N-1:0]   A,
    input  logic [3*N-1:0]   B,
    output logic [N-1:0]     ACK,
    output logic [2:0]       Y,
    output logic [IDW-1:0]   GNT_ID,
    output logic             BUSY
`ifdef OR3_ARB_STATS_EN
    ,
    output logic [8*N-1:0]   GNT_CNT
`endif
);

    state_t           state_q,  state_d;
    logic [IDW-1:0]   ptr_q,    ptr_d;
    logic [IDW-1:0]   gnt_id_q, gnt_id_d;
    logic [OPW-1:0]   op_a_q,   op_a_d;
    logic [OPW-1:0]   op_b_q,   op_b_d;
    logic [OPW-1:0]   y_q,      y_d;
    logic [N-1:0]     ack_q,    ack_d;
    logic             busy_q,   busy_d;

    logic [IDW-1:0]   pick_idx;
    logic             pick_valid;
    logic [OPW-1:0]   or_y;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_rr_pick (
        .req   (REQ),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    MOD_74x32_3 u_or (
        .A (op_a_q),
        .B (op_b_q),
        .Y (or_y)
    );

    // Next-state and datapath updates; ACK defaults low so it drops on RESP exit.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_id_d = gnt_id_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        y_d      = y_q;
        ack_d    = '0;
        busy_d   = busy_q;
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    gnt_id_d = pick_idx;
                    for (int i = 0; i < N; i++) begin
                        if (pick_idx == IDW'(i)) begin
                            op_a_d = A[i*OPW +: OPW];
                            op_b_d = B[i*OPW +: OPW];
                        end
                    end
                    busy_d  = 1'b1;
                    state_d = S_ISSUE;
                end else begin
                    busy_d = 1'b0;
                end
            end
            S_ISSUE: begin
                y_d             = or_y;
                ack_d[gnt_id_q] = 1'b1;
                state_d         = S_RESP;
            end
            S_RESP: begin
                ptr_d   = (gnt_id_q == IDW'(N-1)) ? '0 : gnt_id_q + 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset; reset aborts any
    // in-flight transaction without an ACK.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            gnt_id_q <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            y_q      <= '0;
            ack_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_id_q <= gnt_id_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            y_q      <= y_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
        end
    end

    assign ACK    = ack_q;
    assign Y      = y_q;
    assign GNT_ID = gnt_id_q;
    assign BUSY   = busy_q;

`ifdef OR3_ARB_STATS_EN
    logic [CNTW*N-1:0] gnt_cnt_q, gnt_cnt_d;

    // Bump the granted requester's counter on the ISSUE->RESP edge, holding at max.
    always_comb begin
        gnt_cnt_d = gnt_cnt_q;
        if (state_q == S_ISSUE) begin
            for (int i = 0; i < N; i++) begin
                if (gnt_id_q == IDW'(i) && gnt_cnt_q[i*CNTW +: CNTW] != CNT_MAX) begin
                    gnt_cnt_d[i*CNTW +: CNTW] = gnt_cnt_q[i*CNTW +: CNTW] + 1'b1;
                end
            end
        end
    end

    // Grant counters clear on reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            gnt_cnt_q <= '0;
        end else begin
            gnt_cnt_q <= gnt_cnt_d;
        end
    end

    assign GNT_CNT = gnt_cnt_q;
`endif

endmodule

// File: tb/tb_or3_rr_arbiter.sv
// Directed testbench for or3_rr_arbiter (N=4). Outputs are sampled 1 time
// unit after each rising edge; inputs change at the same point.
module tb_or3_rr_arbiter;

    logic        CLK;
    logic        RST;
    logic [3:0]  REQ;
    logic [11:0] A;
    logic [11:0] B;
    logic [3:0]  ACK;
    logic [2:0]  Y;
    logic [1:0]  GNT_ID;
    logic        BUSY;
`ifdef OR3_ARB_STATS_EN
    logic [31:0] GNT_CNT;
`endif

    int passed;
    int total;

    or3_rr_arbiter #(
        .N   (4),
        .IDW (2)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .REQ    (REQ),
        .A      (A),
        .B      (B),
        .ACK    (ACK),
        .Y      (Y),
        .GNT_ID (GNT_ID),
        .BUSY   (BUSY)
`ifdef OR3_ARB_STATS_EN
        ,
        .GNT_CNT(GNT_CNT)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        REQ = 4'b1111;
        A   = 12'b000_000_000_001;
        B   = 12'b000_000_000_010;
        tick();
        total++; if (ACK !== 4'b0000) $display("FAIL reset_ack: got %b want 0000", ACK); else passed++;
        total++; if (Y !== 3'b000) $display("FAIL reset_y: got %b want 000", Y); else passed++;
        total++; if (BUSY !== 1'b0) $display("FAIL reset_busy: got %b want 0", BUSY); else passed++;
        total++; if (GNT_ID !== 2'd0) $display("FAIL reset_gnt: got %0d want 0", GNT_ID); else passed++;
        tick();
        total++; if (BUSY !== 1'b0) $display("FAIL reset_busy2: got %b want 0", BUSY); else passed++;
        total++; if (ACK !== 4'b0000) $display("FAIL reset_ack2: got %b want 0000", ACK); else passed++;
        RST = 1'b0;
        tick();
        total++; if (BUSY !== 1'b1) $display("FAIL first_grant_busy: got %b want 1", BUSY); else passed++;
        total++; if (GNT_ID !== 2'd0) $display("FAIL first_grant_id: got %0d want 0", GNT_ID); else passed++;
        total++; if (ACK !== 4'b0000) $display("FAIL first_grant_ack: got %b want 0000", ACK); else passed++;
        REQ = 4'b0000;
        tick();
        total++; if (ACK !== 4'b0001) $display("FAIL first_ack: got %b want 0001", ACK); else passed++;
        total++; if (Y !== 3'b011) $display("FAIL first_y: got %b want 011", Y); else passed++;
        tick();
        total++; if (ACK !== 4'b0000) $display("FAIL first_ack_drop: got %b want 0000", ACK); else passed++;
        total++; if (BUSY !== 1'b0) $display("FAIL first_busy_drop: got %b want 0", BUSY); else passed++;
    endtask

    task automatic test_single();
        A[8:6] = 3'b101;
        B[8:6] = 3'b010;
        REQ    = 4'b0100;
        tick();
        total++; if (BUSY !== 1'b1) $display("FAIL single_busy: got %b want 1", BUSY); else passed++;
        total++; if (GNT_ID !== 2'd2) $display("FAIL single_gnt: got %0d want 2", GNT_ID); else passed++;
        total++; if (ACK !== 4'b0000) $display("FAIL single_ack_early: got %b want 0000", ACK); else passed++;
        tick();
        total++; if (ACK !== 4'b0100) $display("FAIL single_ack: got %b want 0100", ACK); else passed++;
        total++; if (Y !== 3'b111) $display("FAIL single_y: got %b want 111", Y); else passed++;
        REQ = 4'b0000;
        tick();
        total++; if (ACK !== 4'b0000) $display("FAIL single_ack_drop: got %b want 0000", ACK); else passed++;
        total++; if (BUSY !== 1'b0) $display("FAIL single_busy_drop: got %b want 0", BUSY); else passed++;
        tick();
        total++; if (BUSY !== 1'b0) $display("FAIL idle_busy: got %b want 0", BUSY); else passed++;
        total++; if (Y !== 3'b111) $display("FAIL idle_y_hold: got %b want 111", Y); else passed++;
        total++; if (GNT_ID !== 2'd2) $display("FAIL idle_gnt_hold: got %0d want 2", GNT_ID); else passed++;
    endtask

    task automatic test_truth_table();
        logic [2:0] tt_a [5];
        logic [2:0] tt_b [5];
        logic [2:0] tt_y [5];
        tt_a = '{3'b000, 3'b111, 3'b000, 3'b111, 3'b100};
        tt_b = '{3'b000, 3'b000, 3'b111, 3'b111, 3'b001};
        tt_y = '{3'b000, 3'b111, 3'b111, 3'b111, 3'b101};
        for (int t = 0; t < 5; t++) begin
            A[2:0] = tt_a[t];
            B[2:0] = tt_b[t];
            REQ    = 4'b0001;
            tick();
            total++; if (GNT_ID !== 2'd0) $display("FAIL tt%0d_gnt: got %0d want 0", t, GNT_ID); else passed++;
            REQ = 4'b0000;
            tick();
            total++; if (ACK !== 4'b0001) $display("FAIL tt%0d_ack: got %b want 0001", t, ACK); else passed++;
            total++; if (Y !== tt_y[t]) $display("FAIL tt%0d_y: got %b want %b", t, Y, tt_y[t]); else passed++;
            tick();
            total++; if (ACK !== 4'b0000) $display("FAIL tt%0d_ack_drop: got %b want 0000", t, ACK); else passed++;
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] rr_y [4];
        logic [1:0] exp_id;
        logic [3:0] exp_ack;
        RST = 1'b1;
        REQ = 4'b0000;
        tick();
        RST = 1'b0;
        A = {3'b100, 3'b010, 3'b001, 3'b110};
        B = {3'b000, 3'b001, 3'b100, 3'b000};
        rr_y = '{3'b110, 3'b101, 3'b011, 3'b100};
        REQ = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_id  = 2'(k % 4);
            exp_ack = 4'b0001 << exp_id;
            tick();
            total++; if (GNT_ID !== exp_id) $display("FAIL rr%0d_gnt: got %0d want %0d", k, GNT_ID, exp_id); else passed++;
            total++; if (ACK !== 4'b0000) $display("FAIL rr%0d_ack_early: got %b want 0000", k, ACK); else passed++;
            tick();
            total++; if (ACK !== exp_ack) $display("FAIL rr%0d_ack: got %b want %b", k, ACK, exp_ack); else passed++;
            total++; if (Y !== rr_y[exp_id]) $display("FAIL rr%0d_y: got %b want %b", k, Y, rr_y[exp_id]); else passed++;
            tick();
            total++; if (ACK !== 4'b0000) $display("FAIL rr%0d_ack_drop: got %b want 0000", k, ACK); else passed++;
        end
        REQ = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid();
        REQ = 4'b1000;
        tick();
        total++; if (GNT_ID !== 2'd3) $display("FAIL mid_gnt3: got %0d want 3", GNT_ID); else passed++;
        total++; if (BUSY !== 1'b1) $display("FAIL mid_busy: got %b want 1", BUSY); else passed++;
        RST = 1'b1;
        REQ = 4'b0000;
        tick();
        total++; if (ACK !== 4'b0000) $display("FAIL mid_ack: got %b want 0000", ACK); else passed++;
        total++; if (Y !== 3'b000) $display("FAIL mid_y: got %b want 000", Y); else passed++;
        total++; if (BUSY !== 1'b0) $display("FAIL mid_busy_clr: got %b want 0", BUSY); else passed++;
        total++; if (GNT_ID !== 2'd0) $display("FAIL mid_gnt_clr: got %0d want 0", GNT_ID); else passed++;
        RST = 1'b0;
        REQ = 4'b1001;
        tick();
        total++; if (GNT_ID !== 2'd0) $display("FAIL mid_next_gnt: got %0d want 0", GNT_ID); else passed++;
        total++; if (ACK !== 4'b0000) $display("FAIL mid_next_ack_early: got %b want 0000", ACK); else passed++;
        REQ = 4'b0000;
        tick();
        total++; if (ACK !== 4'b0001) $display("FAIL mid_next_ack: got %b want 0001", ACK); else passed++;
        total++; if (Y !== 3'b110) $display("FAIL mid_next_y: got %b want 110", Y); else passed++;
        tick();
        total++; if (ACK !== 4'b0000) $display("FAIL mid_next_ack_drop: got %b want 0000", ACK); else passed++;
    endtask

`ifdef OR3_ARB_STATS_EN
    task automatic test_stats();
        RST = 1'b1;
        REQ = 4'b0000;
        tick();
        RST = 1'b0;
        for (int t = 0; t < 300; t++) begin
            REQ = 4'b0010;
            tick();
            REQ = 4'b0000;
            tick();
            tick();
        end
        total++; if (GNT_CNT !== 32'h0000_FF00) $display("FAIL stats_sat: got %h want 0000ff00", GNT_CNT); else passed++;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        total++; if (GNT_CNT !== 32'h0000_0000) $display("FAIL stats_clr: got %h want 00000000", GNT_CNT); else passed++;
    endtask
`endif

    initial begin
        passed = 0;
        total  = 0;
        RST = 1'b1;
        REQ = '0;
        A   = '0;
        B   = '0;
        test_reset();
        test_single();
        test_truth_table();
        test_round_robin();
        test_reset_mid();
`ifdef OR3_ARB_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
